// File: rtl/branch_resolve_unit_if.sv
// Port bundle of the branch resolve unit: fetch-time prediction, E-stage
// outcome, redirect/flush, predictor training and performance counters.
interface branch_resolve_unit_if #(
    parameter int GBIT  = 10,
    parameter int CNT_W = 32
);
    logic              i_stall;
    logic              i_valid_F;
    logic [1:0]        i_br_type_F;
    logic              i_pred_taken_F;
    logic [31:0]       i_pred_target_F;
    logic [31:0]       i_pc_4_F;
    logic [GBIT-1:0]   i_pht_idx_F;
    logic              i_taken_E;
    logic [31:0]       i_target_E;
    logic              o_redirect;
    logic [31:0]       o_redirect_pc;
    logic              o_flush_FD;
    logic              o_upd_en;
    logic              o_upd_taken;
    logic [GBIT-1:0]   o_upd_idx;
    logic [CNT_W-1:0]  o_br_cnt;
    logic [CNT_W-1:0]  o_miss_cnt;

    modport master (
        output i_stall, i_valid_F, i_br_type_F, i_pred_taken_F,
        output i_pred_target_F, i_pc_4_F, i_pht_idx_F,
        output i_taken_E, i_target_E,
        input  o_redirect, o_redirect_pc, o_flush_FD,
        input  o_upd_en, o_upd_taken, o_upd_idx,
        input  o_br_cnt, o_miss_cnt
    );

    modport slave (
        input  i_stall, i_valid_F, i_br_type_F, i_pred_taken_F,
        input  i_pred_target_F, i_pc_4_F, i_pht_idx_F,
        input  i_taken_E, i_target_E,
        output o_redirect, o_redirect_pc, o_flush_FD,
        output o_upd_en, o_upd_taken, o_upd_idx,
        output o_br_cnt, o_miss_cnt
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: tracks gshare predictions F->D->E,
// redirects on mispredict, trains the PHT and counts branches/misses.
module branch_resolve_unit #(
    parameter int GBIT  = 10,
    parameter int CNT_W = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    branch_resolve_unit_if.slave bus
);
    typedef struct packed {
        logic            valid;
        logic [1:0]      br_type;
        logic            pred_taken;
        logic [31:0]     pred_target;
        logic [31:0]     pc_4;
        logic [GBIT-1:0] pht_idx;
    } slot_t;

    localparam logic [1:0]       BR_NONE = 2'b00;
    localparam logic [1:0]       BR_COND = 2'b01;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    slot_t            f_slot;
    slot_t            d_q, d_d;
    slot_t            e_q, e_d;
    logic             upd_en_q, upd_en_d;
    logic             upd_taken_q, upd_taken_d;
    logic [GBIT-1:0]  upd_idx_q, upd_idx_d;
    logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    logic             resolve;
    logic             is_cond;
    logic             mispredict;
    logic [31:0]      fix_pc;

    always_comb begin
        f_slot             = '0;
        f_slot.valid       = bus.i_valid_F;
        f_slot.br_type     = bus.i_br_type_F;
        f_slot.pred_taken  = bus.i_pred_taken_F;
        f_slot.pred_target = bus.i_pred_target_F;
        f_slot.pc_4        = bus.i_pc_4_F;
        f_slot.pht_idx     = bus.i_pht_idx_F;
    end

    // Direction is checked first; a taken branch must also hit the target.
    always_comb begin
        resolve    = e_q.valid && (e_q.br_type != BR_NONE) && !bus.i_stall;
        is_cond    = (e_q.br_type == BR_COND);
        mispredict = 1'b0;
        fix_pc     = bus.i_target_E;
        if (resolve) begin
            if (is_cond && !e_q.pred_taken) begin
                mispredict = bus.i_taken_E;
            end else if (is_cond && !bus.i_taken_E) begin
                mispredict = 1'b1;
                fix_pc     = e_q.pc_4;
            end else begin
                mispredict = (e_q.pred_target != bus.i_target_E);
            end
        end
    end

    assign bus.o_redirect    = mispredict;
    assign bus.o_flush_FD    = mispredict;
    assign bus.o_redirect_pc = mispredict ? fix_pc : 32'h0;

    always_comb begin
        d_d = d_q;
        e_d = e_q;
        if (!bus.i_stall) begin
            d_d = f_slot;
            e_d = d_q;
            // Younger slots are wrong-path once E redirects.
            if (mispredict) begin
                d_d.valid = 1'b0;
                e_d.valid = 1'b0;
            end
        end
    end

    always_comb begin
        upd_en_d    = resolve && is_cond;
        upd_taken_d = upd_taken_q;
        upd_idx_d   = upd_idx_q;
        br_cnt_d    = br_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (resolve && is_cond) begin
            upd_taken_d = bus.i_taken_E;
            upd_idx_d   = e_q.pht_idx;
            if (br_cnt_q != CNT_MAX) begin
                br_cnt_d = br_cnt_q + CNT_ONE;
            end
        end
        if (mispredict && (miss_cnt_q != CNT_MAX)) begin
            miss_cnt_d = miss_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            d_q         <= '0;
            e_q         <= '0;
            upd_en_q    <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_idx_q   <= '0;
            br_cnt_q    <= '0;
            miss_cnt_q  <= '0;
        end else begin
            d_q         <= d_d;
            e_q         <= e_d;
            upd_en_q    <= upd_en_d;
            upd_taken_q <= upd_taken_d;
            upd_idx_q   <= upd_idx_d;
            br_cnt_q    <= br_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    assign bus.o_upd_en     = upd_en_q;
    assign bus.o_upd_taken  = upd_taken_q;
    assign bus.o_upd_idx    = upd_idx_q;
    assign bus.o_br_cnt     = br_cnt_q;
    assign bus.o_miss_cnt   = miss_cnt_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized traffic
// against an in-flight-prediction queue model (4-bit counters for saturation).
module tb_branch_resolve_unit;
    localparam int GBIT  = 10;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    branch_resolve_unit_if #(.GBIT(GBIT), .CNT_W(CNT_W)) bi();

    branch_resolve_unit #(.GBIT(GBIT), .CNT_W(CNT_W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bi.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            valid;
        bit [1:0]      typ;
        bit            pred;
        bit [31:0]     ptgt;
        bit [31:0]     pc4;
        bit [GBIT-1:0] idx;
    } pred_t;

    pred_t         pipe[$];
    bit            m_upd_en;
    bit            m_upd_taken;
    bit [GBIT-1:0] m_upd_idx;
    int            m_br;
    int            m_miss;

    function automatic void model_reset();
        pred_t b;
        b = '{default: 0};
        pipe.delete();
        pipe.push_back(b);
        pipe.push_back(b);
        m_upd_en = 0;
        m_upd_taken = 0;
        m_upd_idx = '0;
        m_br = 0;
        m_miss = 0;
    endfunction

    // Actual vs predicted path; JAL/JALR are always-taken jumps.
    function automatic void model_expect(output bit mis, output bit [31:0] pc);
        pred_t e;
        bit act, prd;
        e = pipe[1];
        mis = 0;
        pc = 0;
        if (bi.i_stall || !e.valid || e.typ == 2'b00) return;
        act = (e.typ == 2'b01) ? bi.i_taken_E : 1'b1;
        prd = (e.typ == 2'b01) ? e.pred : 1'b1;
        mis = (act != prd) || (act && e.ptgt != bi.i_target_E);
        pc = act ? bi.i_target_E : e.pc4;
    endfunction

    task automatic model_edge();
        bit mis;
        bit [31:0] pc;
        pred_t e, f;
        model_expect(mis, pc);
        e = pipe[1];
        m_upd_en = 0;
        if (!bi.i_stall && e.valid && e.typ == 2'b01) begin
            m_upd_en = 1;
            m_upd_taken = bi.i_taken_E;
            m_upd_idx = e.idx;
            if (m_br < CMAX) m_br++;
        end
        if (mis && m_miss < CMAX) m_miss++;
        if (!bi.i_stall) begin
            f.valid = bi.i_valid_F;
            f.typ = bi.i_br_type_F;
            f.pred = bi.i_pred_taken_F;
            f.ptgt = bi.i_pred_target_F;
            f.pc4 = bi.i_pc_4_F;
            f.idx = bi.i_pht_idx_F;
            pipe.push_front(f);
            void'(pipe.pop_back());
            if (mis) begin
                pipe[0].valid = 0;
                pipe[1].valid = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive_f(bit v, bit [1:0] t, bit p, bit [31:0] tgt,
                           bit [31:0] pc4, bit [GBIT-1:0] idx);
        bi.i_valid_F = v;
        bi.i_br_type_F = t;
        bi.i_pred_taken_F = p;
        bi.i_pred_target_F = tgt;
        bi.i_pc_4_F = pc4;
        bi.i_pht_idx_F = idx;
    endtask

    task automatic set_e(bit tk, bit [31:0] tgt);
        bi.i_taken_E = tk;
        bi.i_target_E = tgt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        bi.i_stall = 0;
        drive_f(0, 0, 0, 0, 0, 0);
        set_e(0, 0);
        model_reset();
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1;
        bi.i_stall = 0;
        drive_f(0, 0, 0, 0, 0, 0);
        set_e(0, 0);
        model_reset();
        #2;
        checks++;
        if (bi.o_redirect !== 1'b0 || bi.o_flush_FD !== 1'b0 || bi.o_redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_redirect got %b/%b/%h exp 0/0/0", bi.o_redirect, bi.o_flush_FD, bi.o_redirect_pc);
        end
        checks++;
        if (bi.o_upd_en !== 1'b0 || bi.o_upd_taken !== 1'b0 || bi.o_upd_idx !== '0) begin
            errors++;
            $display("FAIL reset_upd got %b/%b/%h exp 0/0/0", bi.o_upd_en, bi.o_upd_taken, bi.o_upd_idx);
        end
        checks++;
        if (bi.o_br_cnt !== '0 || bi.o_miss_cnt !== '0) begin
            errors++;
            $display("FAIL reset_cnt got %0d/%0d exp 0/0", bi.o_br_cnt, bi.o_miss_cnt);
        end
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_correct_pred();
        do_reset();
        drive_f(1, 2'b01, 1, 32'h100, 32'h14, 10'h2A);
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        cycle();
        set_e(1, 32'h100);
        #1;
        checks++;
        if (bi.o_redirect !== 1'b0) begin
            errors++;
            $display("FAIL correct_redirect got %b exp 0", bi.o_redirect);
        end
        cycle();
        checks++;
        if (bi.o_upd_en !== 1'b1 || bi.o_upd_taken !== 1'b1 || bi.o_upd_idx !== 10'h2A) begin
            errors++;
            $display("FAIL correct_upd got %b/%b/%h exp 1/1/02a", bi.o_upd_en, bi.o_upd_taken, bi.o_upd_idx);
        end
        checks++;
        if (bi.o_br_cnt !== 4'd1 || bi.o_miss_cnt !== 4'd0) begin
            errors++;
            $display("FAIL correct_cnt got %0d/%0d exp 1/0", bi.o_br_cnt, bi.o_miss_cnt);
        end
    endtask

    task automatic test_taken_not_pred();
        do_reset();
        drive_f(1, 2'b01, 0, 32'h48, 32'h44, 10'h01);
        cycle();
        drive_f(1, 2'b10, 1, 32'h999, 32'h4C, 10'h02);
        cycle();
        drive_f(1, 2'b10, 1, 32'h999, 32'h50, 10'h03);
        set_e(1, 32'h80);
        #1;
        checks++;
        if (bi.o_redirect !== 1'b1 || bi.o_redirect_pc !== 32'h80 || bi.o_flush_FD !== 1'b1) begin
            errors++;
            $display("FAIL tnp_redirect got %b/%h/%b exp 1/00000080/1", bi.o_redirect, bi.o_redirect_pc, bi.o_flush_FD);
        end
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        checks++;
        if (bi.o_redirect !== 1'b0) begin
            errors++;
            $display("FAIL tnp_bubble_e got %b exp 0", bi.o_redirect);
        end
        cycle();
        checks++;
        if (bi.o_redirect !== 1'b0) begin
            errors++;
            $display("FAIL tnp_bubble_d got %b exp 0", bi.o_redirect);
        end
        checks++;
        if (bi.o_miss_cnt !== 4'd1 || bi.o_br_cnt !== 4'd1) begin
            errors++;
            $display("FAIL tnp_cnt got %0d/%0d exp 1/1", bi.o_br_cnt, bi.o_miss_cnt);
        end
    endtask

    task automatic test_not_taken_jalr();
        do_reset();
        drive_f(1, 2'b01, 1, 32'h100, 32'h48, 10'h15);
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        cycle();
        set_e(0, 32'h100);
        #1;
        checks++;
        if (bi.o_redirect !== 1'b1 || bi.o_redirect_pc !== 32'h48) begin
            errors++;
            $display("FAIL ntk_redirect got %b/%h exp 1/00000048", bi.o_redirect, bi.o_redirect_pc);
        end
        cycle();
        checks++;
        if (bi.o_upd_en !== 1'b1 || bi.o_upd_taken !== 1'b0 || bi.o_upd_idx !== 10'h15) begin
            errors++;
            $display("FAIL ntk_upd got %b/%b/%h exp 1/0/015", bi.o_upd_en, bi.o_upd_taken, bi.o_upd_idx);
        end
        drive_f(1, 2'b11, 1, 32'h200, 32'h60, 10'h33);
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        cycle();
        set_e(1, 32'h300);
        #1;
        checks++;
        if (bi.o_redirect !== 1'b1 || bi.o_redirect_pc !== 32'h300) begin
            errors++;
            $display("FAIL jalr_redirect got %b/%h exp 1/00000300", bi.o_redirect, bi.o_redirect_pc);
        end
        cycle();
        checks++;
        if (bi.o_upd_en !== 1'b0 || bi.o_upd_idx !== 10'h15) begin
            errors++;
            $display("FAIL jalr_noupd got %b/%h exp 0/015", bi.o_upd_en, bi.o_upd_idx);
        end
        checks++;
        if (bi.o_br_cnt !== 4'd1 || bi.o_miss_cnt !== 4'd2) begin
            errors++;
            $display("FAIL jalr_cnt got %0d/%0d exp 1/2", bi.o_br_cnt, bi.o_miss_cnt);
        end
    endtask

    task automatic test_stall();
        do_reset();
        drive_f(1, 2'b01, 0, 32'h0, 32'h24, 10'h07);
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        cycle();
        set_e(1, 32'h80);
        bi.i_stall = 1;
        drive_f(1, 2'b10, 1, 32'h999, 32'h70, 10'h3F);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (bi.o_redirect !== 1'b0) begin
                errors++;
                $display("FAIL stall_redirect[%0d] got %b exp 0", i, bi.o_redirect);
            end
            cycle();
            checks++;
            if (bi.o_upd_en !== 1'b0 || bi.o_miss_cnt !== 4'd0) begin
                errors++;
                $display("FAIL stall_hold[%0d] got %b/%0d exp 0/0", i, bi.o_upd_en, bi.o_miss_cnt);
            end
        end
        bi.i_stall = 0;
        drive_f(0, 0, 0, 0, 0, 0);
        #1;
        checks++;
        if (bi.o_redirect !== 1'b1 || bi.o_redirect_pc !== 32'h80) begin
            errors++;
            $display("FAIL stall_release got %b/%h exp 1/00000080", bi.o_redirect, bi.o_redirect_pc);
        end
        cycle();
        checks++;
        if (bi.o_upd_en !== 1'b1 || bi.o_upd_idx !== 10'h07 || bi.o_miss_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_upd got %b/%h/%0d exp 1/007/1", bi.o_upd_en, bi.o_upd_idx, bi.o_miss_cnt);
        end
        cycle();
        checks++;
        if (bi.o_upd_en !== 1'b0 || bi.o_redirect !== 1'b0 || bi.o_miss_cnt !== 4'd1 || bi.o_br_cnt !== 4'd1) begin
            errors++;
            $display("FAIL stall_once got %b/%b/%0d/%0d exp 0/0/1/1", bi.o_upd_en, bi.o_redirect, bi.o_miss_cnt, bi.o_br_cnt);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive_f(1, 2'b01, 0, 32'h0, 32'h24, 10'h11);
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        cycle();
        set_e(1, 32'h80);
        cycle();
        drive_f(1, 2'b01, 0, 32'h0, 32'h34, 10'h22);
        cycle();
        drive_f(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1;
        #1;
        checks++;
        if (bi.o_br_cnt !== '0 || bi.o_miss_cnt !== '0 || bi.o_upd_idx !== '0) begin
            errors++;
            $display("FAIL arst_clear got %0d/%0d/%h exp 0/0/000", bi.o_br_cnt, bi.o_miss_cnt, bi.o_upd_idx);
        end
        model_reset();
        #1;
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (bi.o_redirect !== 1'b0 || bi.o_upd_en !== 1'b0) begin
                errors++;
                $display("FAIL arst_noupd[%0d] got %b/%b exp 0/0", i, bi.o_redirect, bi.o_upd_en);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_e(1, 32'h80);
        for (int i = 0; i < 20; i++) begin
            drive_f(1, 2'b01, 0, 32'h0, 32'h44, 10'(i));
            cycle();
            drive_f(0, 0, 0, 0, 0, 0);
            cycle();
            checks++;
            if (bi.o_redirect !== 1'b1) begin
                errors++;
                $display("FAIL sat_redirect[%0d] got %b exp 1", i, bi.o_redirect);
            end
            cycle();
        end
        checks++;
        if (bi.o_br_cnt !== 4'hF || bi.o_miss_cnt !== 4'hF) begin
            errors++;
            $display("FAIL sat_cnt got %h/%h exp f/f", bi.o_br_cnt, bi.o_miss_cnt);
        end
    endtask

    task automatic test_random();
        bit mis;
        bit [31:0] pc;
        bit [31:0] tg[3];
        bit [1:0] t;
        tg[0] = 32'h100;
        tg[1] = 32'h200;
        tg[2] = 32'h300;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            t = 2'($urandom_range(0, 3));
            drive_f($urandom_range(0, 9) < 7, t,
                    (t[1]) ? 1'b1 : 1'($urandom),
                    tg[$urandom_range(0, 2)],
                    {$urandom_range(0, 255), 2'b00}, GBIT'($urandom));
            bi.i_stall = ($urandom_range(0, 4) == 0);
            set_e(1'($urandom), tg[$urandom_range(0, 2)]);
            #1;
            model_expect(mis, pc);
            checks++;
            if (bi.o_redirect !== mis || bi.o_flush_FD !== mis || (mis && bi.o_redirect_pc !== pc)) begin
                errors++;
                $display("FAIL rnd_redirect[%0d] got %b/%b/%h exp %b/%b/%h", n, bi.o_redirect, bi.o_flush_FD, bi.o_redirect_pc, mis, mis, pc);
            end
            checks++;
            if (bi.o_upd_en !== m_upd_en || bi.o_upd_taken !== m_upd_taken || bi.o_upd_idx !== m_upd_idx) begin
                errors++;
                $display("FAIL rnd_upd[%0d] got %b/%b/%h exp %b/%b/%h", n, bi.o_upd_en, bi.o_upd_taken, bi.o_upd_idx, m_upd_en, m_upd_taken, m_upd_idx);
            end
            checks++;
            if (bi.o_br_cnt !== CNT_W'(m_br) || bi.o_miss_cnt !== CNT_W'(m_miss)) begin
                errors++;
                $display("FAIL rnd_cnt[%0d] got %0d/%0d exp %0d/%0d", n, bi.o_br_cnt, bi.o_miss_cnt, m_br, m_miss);
            end
            cycle();
        end
        bi.i_stall = 0;
    endtask

    initial begin
        test_reset();
        test_correct_pred();
        test_taken_not_pred();
        test_not_taken_jalr();
        test_stall();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-stage counterpart of the fetch-stage gshare predictor.
- Carries each fetch-time prediction (direction, target, PHT index) down the F->D->E pipeline, then compares it with the outcome computed in E.
- On a mismatch it raises a redirect/flush. For every resolved conditional branch it returns a registered training update (enable, taken, PHT index) to the predictor, and it keeps saturating performance counters.

Parameters:
- GBIT, 10, PHT index width; must match the predictor.
- CNT_W, 32, width of the performance counters.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_stall  in  1  hazard stall: holds all tracking registers and suppresses resolution.
- i_valid_F  in  1  fetch slot holds a real instruction.
- i_br_type_F  in  2  00 none, 01 conditional branch, 10 JAL, 11 JALR.
- i_pred_taken_F  in  1  predictor direction (JAL/JALR: always 1).
- i_pred_target_F  in  32  predicted target PC.
- i_pc_4_F  in  32  fall-through PC of the fetched instruction.
- i_pht_idx_F  in  GBIT  PHT index used for the prediction.
- i_taken_E  in  1  actual branch condition from the E-stage comparator.
- i_target_E  in  32  actual target from E (pc+imm_b, pc+imm_j or rs1+imm).
- o_redirect  out  1  mispredict in E this cycle (combinational).
- o_redirect_pc  out  32  correct next PC (valid when o_redirect).
- o_flush_FD  out  1  kill the F and D slots; equals o_redirect.
- o_upd_en  out  1  predictor training strobe (registered).
- o_upd_taken  out  1  actual outcome for training.
- o_upd_idx  out  GBIT  PHT index to train.
- o_br_cnt  out  CNT_W  resolved conditional branches.
- o_miss_cnt  out  CNT_W  redirects issued.

Behaviour:
- **Reset (async, i_rst=1).** Clears:
  - D/E valid bits;
  - all payload registers;
  - o_upd_en, o_upd_taken, o_upd_idx;
  - both counters.
  - Consequently o_redirect, o_flush_FD and o_redirect_pc read 0.
  - Reset mid-operation discards in-flight predictions; no update is emitted for them.
- **Tracking pipeline.** Two register stages, D and E. Each holds {valid, br_type, pred_taken, pred_target, pc_4, pht_idx}.
  - When i_stall=1, both stages hold.
  - Otherwise D <= F inputs (valid = i_valid_F) and E <= D.
  - When o_redirect=1 and i_stall=0, D and E load valid=0 at the next edge (wrong-path bubbles). This flush overrides capture of F.
- **Resolution.** Evaluated combinationally when E.valid=1, E.br_type!=00 and i_stall=0:
  - cond, actual=i_taken_E, pred=0: mispredict if actual=1; redirect_pc=i_target_E.
  - cond, pred=1: mispredict if actual=0 (redirect_pc=E.pc_4). Also mispredict if actual=1 and E.pred_target!=i_target_E (redirect_pc=i_target_E).
  - JAL or JALR: mispredict if E.pred_target!=i_target_E; redirect_pc=i_target_E. JALR is normally caught here.
  - When i_stall=1, o_redirect=0 and resolution is deferred until the stall drops.
- **Training update.** Exactly one cycle after a conditional branch resolves (E valid, type 01, not stalled):
  - o_upd_en=1, o_upd_taken=i_taken_E, o_upd_idx=E.pht_idx.
  - Otherwise o_upd_en=0; o_upd_taken and o_upd_idx hold.
  - JAL/JALR never train.
- **Counters.** Updated on the same edge as the training update.
  - o_br_cnt +1 per conditional resolution.
  - o_miss_cnt +1 per redirect of any type.
  - Both saturate at all-ones and never wrap.
- **Latency.** A prediction presented at F edge n resolves in the cycle after edge n+2, assuming no stalls. The update becomes visible after edge n+3.

Test Plan:
- **Correct prediction.** Cond branch, pred_taken=1, target 0x100; E: taken=1, target 0x100 -> o_redirect=0; next cycle o_upd_en=1, taken=1, idx echoed; br_cnt=1, miss_cnt=0.
- **Taken when predicted not-taken.** Cond, pred=0, pc_4=0x44; E: taken=1, target=0x80 -> o_redirect=1, o_redirect_pc=0x80, flush; the two younger valid slots become bubbles; miss_cnt=1.
- **Not taken when predicted taken, then JALR.**
  - Cond, pred=1, pc_4=0x48, E taken=0 -> redirect_pc=0x48, upd_taken=0.
  - JALR with pred_target 0x200, target_E 0x300 -> redirect 0x300, o_upd_en stays 0.
- **Stall during resolution.** Mispredicting branch in E with i_stall=1 for 3 cycles -> o_redirect=0 and registers hold throughout; redirect asserted in the first unstalled cycle; exactly one update, one miss count.
- **Async reset and saturation.**
  - Assert i_rst between clock edges with a branch in D -> outputs clear immediately; no update after release.
  - With CNT_W=4, 20 mispredicting cond branches -> both counters stick at 4'hF.
